// File: rtl/dma_block_ctrl_if.sv
// Bus bundle for dma_block_ctrl: control handshake, parallel-input port and shared data-memory port.
// The master modport is the DMA controller's view; slave is the surrounding system's view.
interface dma_block_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = 8
);
  logic              start;
  logic              abort;
  logic              src_mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dest_addr;
  logic [LEN_W-1:0]  length;
  logic [DATA_W-1:0] port_data;
  logic              port_valid;
  logic              port_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_gnt;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  remaining;
  logic              irq;
  logic              irq_clr;

  modport master (
    input  start, abort, src_mode, src_addr, dest_addr, length,
    input  port_data, port_valid, mem_rdata, mem_gnt, irq_clr,
    output port_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output busy, done, remaining, irq
  );

  modport slave (
    output start, abort, src_mode, src_addr, dest_addr, length,
    output port_data, port_valid, mem_rdata, mem_gnt, irq_clr,
    input  port_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  busy, done, remaining, irq
  );
endinterface

// File: rtl/dma_block_ctrl.sv
// Block DMA: moves LENGTH words from the parallel port or a memory region into data memory.
// Define DMA_IRQ_EN to build a sticky completion interrupt flag (irq / irq_clr).
module dma_block_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned ADDR_STEP = 1
) (
  input logic              clock_reg,
  input logic              reset,
  dma_block_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              mode_q, mode_d;

  logic              port_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_ff @(posedge clock_reg or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      buf_q       <= '0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      buf_q       <= buf_d;
      mode_q      <= mode_d;
    end
  end

  // Outputs depend on state only, so mem_* hold steady for as long as a grant is withheld.
  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    buf_d       = buf_q;
    mode_d      = mode_q;
    port_ready  = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          src_ptr_d   = bus.src_addr;
          dst_ptr_d   = bus.dest_addr;
          remaining_d = bus.length;
          mode_d      = bus.src_mode;
          state_d     = (bus.length == '0) ? StDone : StRead;
        end
      end

      StRead: begin
        if (mode_q) begin
          mem_req  = 1'b1;
          mem_addr = src_ptr_q;
          if (bus.mem_gnt) begin
            buf_d   = bus.mem_rdata;
            state_d = StWrite;
          end
        end else begin
          port_ready = 1'b1;
          if (bus.port_valid) begin
            buf_d   = bus.port_data;
            state_d = StWrite;
          end
        end
        // Abort discards the word being fetched.
        if (bus.abort) begin
          buf_d   = buf_q;
          state_d = StIdle;
        end
      end

      StWrite: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dst_ptr_q;
        mem_wdata = buf_q;
        if (bus.mem_gnt) begin
          dst_ptr_d   = dst_ptr_q + ADDR_W'(ADDR_STEP);
          if (mode_q) begin
            src_ptr_d = src_ptr_q + ADDR_W'(ADDR_STEP);
          end
          remaining_d = remaining_q - LEN_W'(1);
          state_d     = (remaining_q == LEN_W'(1)) ? StDone : StRead;
        end
        // A granted write has already landed in memory; only the next state is overridden.
        if (bus.abort) begin
          state_d = StIdle;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.port_ready = port_ready;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.remaining  = remaining_q;

`ifdef DMA_IRQ_EN
  logic irq_q, irq_d;

  // Completion takes priority over a simultaneous clear.
  always_comb begin
    irq_d = irq_q;
    if (state_q == StDone) begin
      irq_d = 1'b1;
    end else if (bus.irq_clr) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clock_reg or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = bus.irq_clr;
  assign bus.irq        = 1'b0;
`endif

endmodule
